regfile_write_arbiter: RTL and testbench

Controller for the register file's single write port. After reset, and on request, it sweeps every register to zero, since the register file has no reset of its own. In normal operation it round-robin arbitrates two valid/ready write requesters (e.g. ALU writeback and load/multi-cycle unit) onto `RegWrite`/`WriteReg`/`WriteData`, silently discarding writes to register 0.

---
 rtl/regfile_write_arbiter_if.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the two valid/ready write requesters and the register-file write
// port driven by regfile_write_arbiter.
//   req0_valid/addr/data -> requester 0 write request, req0_ready <- grant
//   req1_valid/addr/data -> requester 1 write request, req1_ready <- grant
//   RegWrite/WriteReg/WriteData <- registered register-file write port
// Modports: master = requesters + register file side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  RegWrite, WriteReg, WriteData
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output RegWrite, WriteReg, WriteData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the register file's single write port. After reset (and on
// clear_req) it sweeps registers 0..NREG-1 to zero, because the register
// file has no reset. In RUN it round-robin arbitrates two valid/ready
// requesters onto the registered write port; writes to register 0 are
// acknowledged but never asserted on RegWrite.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   clear_req  - one-cycle pulse, restart the zero sweep (ignored in CLEAR)
//   bus        - requester handshakes and RegWrite/WriteReg/WriteData
//   init_done  - high while in RUN
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    regfile_write_arbiter_if.slave  bus,
    output logic                    init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          prio;        // requester favoured when both are valid
    logic          grant0, grant1;
    logic          acc0, acc1;

    // State register plus the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CLEAR;
            cnt           <= '0;
            prio          <= 1'b0;
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == CLEAR) begin
                bus.RegWrite  <= 1'b1;
                bus.WriteReg  <= cnt;
                bus.WriteData <= '0;
            end else if (acc0) begin
                bus.RegWrite  <= |bus.req0_addr;
                bus.WriteReg  <= bus.req0_addr;
                bus.WriteData <= bus.req0_data;
                prio          <= 1'b1;
            end else if (acc1) begin
                bus.RegWrite  <= |bus.req1_addr;
                bus.WriteReg  <= bus.req1_addr;
                bus.WriteData <= bus.req1_data;
                prio          <= 1'b0;
            end else begin
                // Address/data hold their last values when idle.
                bus.RegWrite  <= 1'b0;
            end
        end
    end

    // Next-state logic: sweep counter in CLEAR, clear_req re-entry from RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (cnt == AW'(NREG - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: grant is combinational on valid, gated by RUN and clear_req.
    // rst is folded in so readys are low before the first reset edge.
    always_comb begin
        grant0         = bus.req0_valid & (~bus.req1_valid | ~prio);
        grant1         = bus.req1_valid & (~bus.req0_valid |  prio);
        bus.req0_ready = ~rst & (state == RUN) & ~clear_req & grant0;
        bus.req1_ready = ~rst & (state == RUN) & ~clear_req & grant1;
        acc0           = bus.req0_ready & bus.req0_valid;
        acc1           = bus.req1_ready & bus.req1_valid;
        init_done      = (state == RUN);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Scoreboard bench: the driver keeps a behavioural model (sweep countdown,
// round-robin favourite, reference register contents) and pushes every
// write the register file should see into a queue; an independent monitor
// pops and compares on each cycle where RegWrite is high.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_req = 1'b0;
    logic init_done;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .bus       (bus),
        .init_done (init_done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           expq[$];
    wr_t           mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] rf      [NREG];   // register file fed by the DUT write port
    logic [DW-1:0] ref_mem [NREG];   // expected register contents
    int            sweep_left = NREG;
    bit            mprio = 1'b0;
    bit            model_valid = 1'b0;
    int            grant_log[$];

    always @(posedge clk) if (bus.RegWrite === 1'b1) rf[bus.WriteReg] <= bus.WriteData;

    // Monitor: every asserted write must be the next expected one.
    always @(negedge clk) begin
        if (bus.RegWrite === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %h, expected no write",
                         bus.WriteReg, bus.WriteData);
            end else begin
                mon_e = expq.pop_front();
                if (bus.WriteReg !== mon_e.addr || bus.WriteData !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_port: got addr %0d data %h, expected addr %0d data %h",
                             bus.WriteReg, bus.WriteData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_sweep();
        for (int k = 0; k < int'(NREG); k++) begin
            expq.push_back('{addr: AW'(k), data: '0});
            ref_mem[k] = '0;
        end
    endtask

    task automatic check_mem();
        for (int k = 0; k < int'(NREG); k++)
            chk($sformatf("reg%0d", k), 64'(rf[k]), 64'(ref_mem[k]));
    endtask

    task automatic arm0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    endtask

    task automatic arm1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    endtask

    // One clock: check readys mid-cycle, advance model on the edge,
    // then release any accepted request 1 time unit after the edge.
    task automatic step();
        bit ok, e0, e1;
        @(negedge clk);
        ok = !rst && sweep_left == 0 && !clear_req;
        e0 = ok && bus.req0_valid && (!bus.req1_valid || !mprio);
        e1 = ok && bus.req1_valid && (!bus.req0_valid || mprio);
        chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
        if (model_valid)
            chk("init_done", 64'(init_done), 64'(!rst && sweep_left == 0));
        @(posedge clk);
        if (rst) begin
            model_valid = 1'b1;
            expq.delete();
            sweep_left = NREG;
            mprio = 1'b0;
            push_sweep();
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (clear_req) begin
            sweep_left = NREG;
            push_sweep();
        end else if (e0 || e1) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = e0 ? bus.req0_addr : bus.req1_addr;
            d = e0 ? bus.req0_data : bus.req1_data;
            mprio = e0;
            grant_log.push_back(e0 ? 0 : 1);
            if (a != '0) begin
                expq.push_back('{addr: a, data: d});
                ref_mem[a] = d;
            end
        end
        #1;
        if (e0) bus.req0_valid = 1'b0;
        if (e1) bus.req1_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (bus.req0_valid || bus.req1_valid); i++) step();
        chk("drain_timeout", 64'(bus.req0_valid | bus.req1_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

        // Reset, then idle through the initial sweep.
        rst = 1'b1;
        step();
        step();
        chk("rst_RegWrite",  64'(bus.RegWrite),  64'd0);
        chk("rst_WriteReg",  64'(bus.WriteReg),  64'd0);
        chk("rst_WriteData", 64'(bus.WriteData), 64'd0);
        chk("rst_init_done", 64'(init_done),     64'd0);
        rst = 1'b0;
        for (int i = 0; i < 34; i++) step();
        chk("idle_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("idle_queue_empty", 64'(expq.size()), 64'd0);
        check_mem();

        // Single requester.
        arm0(AW'(5), 32'hDEADBEEF);
        step();
        chk("req0_same_cycle", 64'(bus.req0_valid), 64'd0);
        chk("single_RegWrite",  64'(bus.RegWrite),  64'd1);
        chk("single_WriteReg",  64'(bus.WriteReg),  64'd5);
        chk("single_WriteData", 64'(bus.WriteData), 64'hDEADBEEF);
        step();
        chk("reg5", 64'(rf[5]), 64'hDEADBEEF);

        // Register 0 write from requester 1 (also returns favourite to 0).
        arm1(AW'(0), 32'h1234);
        step();
        chk("req1_reg0_accepted", 64'(bus.req1_valid), 64'd0);
        chk("reg0_RegWrite", 64'(bus.RegWrite), 64'd0);
        step();
        chk("reg0_zero", 64'(rf[0]), 64'd0);

        // Contention: both valid for 6 cycles, distinct addresses.
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            if (!bus.req0_valid) arm0(AW'(10 + i), $urandom);
            if (!bus.req1_valid) arm1(AW'(20 + i), $urandom);
            step();
        end
        chk("contend_grants", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("contend_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
        drain(8);

        // clear_req collides with a request.
        step();
        clear_req = 1'b1;
        arm0(AW'(7), 32'hA5A5_0F0F);
        step();
        clear_req = 1'b0;
        chk("clear_blocks_req0", 64'(bus.req0_valid), 64'd1);
        chk("clear_init_done",   64'(init_done),      64'd0);
        n = 0;
        while (bus.req0_valid && n < 40) begin
            step();
            n++;
        end
        chk("clear_accept_delay", 64'(n), 64'd33);
        step();
        step();
        chk("reg7", 64'(rf[7]), 64'hA5A5_0F0F);

        // Reset in the middle of a sweep (cnt = 17).
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 17; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_RegWrite",  64'(bus.RegWrite), 64'd0);
        chk("midrst_init_done", 64'(init_done),    64'd0);
        step();
        chk("midrst_restart_addr", 64'(bus.WriteReg), 64'd0);
        for (int i = 0; i < 34; i++) step();
        check_mem();

        // Randomised traffic with occasional clear_req and reset.
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0)
                arm0(AW'($urandom_range(0, NREG - 1)), $urandom);
            if (!bus.req1_valid && $urandom_range(0, 2) == 0)
                arm1(AW'($urandom_range(0, NREG - 1)), $urandom);
            clear_req = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        clear_req = 1'b0;
        rst = 1'b0;
        drain(80);
        for (int i = 0; i < 40; i++) step();
        chk("final_queue_empty", 64'(expq.size()), 64'd0);
        check_mem();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
